display_timing_gen: RTL and testbench

//   Parameterised display timing generator; default timing is 640x480 @ 60 Hz.

---
 rtl/display_timing_gen.sv | 138 +++++++++++++
 tb/tb_display_timing_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// Raster timing generator: coordinates, sync pulses, data enable, line/frame strobes
// and a frame counter. Every output is a flop decoded from next-state counter values.

module display_timing_axis #(
  parameter int CORDW = 10,
  parameter int RES   = 640,
  parameter int FP    = 16,
  parameter int SYNC  = 96,
  parameter int BP    = 48,
  parameter int POL   = 0
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             step,
  output logic [CORDW-1:0] pos,
  output logic             last,
  output logic             sync,
  output logic             act_nxt,
  output logic             zero_nxt
);
  localparam int TOTAL = RES + FP + SYNC + BP;
  localparam logic [CORDW-1:0] POS_LAST = CORDW'(TOTAL - 1);
  localparam logic [CORDW-1:0] SYNC_BEG = CORDW'(RES + FP);
  localparam logic [CORDW-1:0] SYNC_END = CORDW'(RES + FP + SYNC - 1);
  localparam logic [CORDW-1:0] ACT_END  = CORDW'(RES);
  localparam logic             ACT_LVL  = (POL != 0);

  logic [CORDW-1:0] pos_nxt;
  logic             sync_nxt;

  always_comb begin
    last    = (pos == POS_LAST);
    pos_nxt = pos;
    if (step) pos_nxt = last ? '0 : pos + 1'b1;
    sync_nxt = (pos_nxt >= SYNC_BEG) && (pos_nxt <= SYNC_END);
    act_nxt  = (pos_nxt < ACT_END);
    zero_nxt = (pos_nxt == '0);
  end

  // Reset parks the counter on its last value so the first edge lands on 0.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      pos  <= POS_LAST;
      sync <= ~ACT_LVL;
    end else begin
      pos  <= pos_nxt;
      sync <= sync_nxt ? ACT_LVL : ~ACT_LVL;
    end
  end
endmodule

module display_timing_gen #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int FRAMEW = 16
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line,
  output logic              frame,
  output logic [FRAMEW-1:0] frame_cnt
);
  localparam longint H_TOTAL = longint'(H_RES + H_FP + H_SYNC + H_BP);
  localparam longint V_TOTAL = longint'(V_RES + V_FP + V_SYNC + V_BP);
  localparam longint CORD_SPAN = longint'(1) << CORDW;

  if (H_TOTAL > CORD_SPAN || V_TOTAL > CORD_SPAN) begin : g_bad_cordw
    $error("display_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_RES == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_RES == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("display_timing_gen: timing parameters must be non-zero");
  end

  logic h_last, h_act_nxt, h_zero_nxt;
  logic v_last, v_act_nxt, v_zero_nxt;
  logic first_frame;

  display_timing_axis #(
    .CORDW(CORDW), .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
  ) u_h (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .step     (1'b1),
    .pos      (sx),
    .last     (h_last),
    .sync     (hsync),
    .act_nxt  (h_act_nxt),
    .zero_nxt (h_zero_nxt)
  );

  // Vertical axis advances only on the horizontal wrap.
  display_timing_axis #(
    .CORDW(CORDW), .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
  ) u_v (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .step     (h_last),
    .pos      (sy),
    .last     (v_last),
    .sync     (vsync),
    .act_nxt  (v_act_nxt),
    .zero_nxt (v_zero_nxt)
  );

  // The entry into (0,0) straight out of reset starts frame 0 rather than ending one.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      de          <= 1'b0;
      line        <= 1'b0;
      frame       <= 1'b0;
      frame_cnt   <= '0;
      first_frame <= 1'b1;
    end else begin
      de    <= h_act_nxt && v_act_nxt;
      line  <= h_zero_nxt;
      frame <= h_zero_nxt && v_zero_nxt;
      if (h_last && v_last) begin
        if (first_frame) first_frame <= 1'b0;
        else             frame_cnt   <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: default 640x480 instance plus two small-timing
// instances (active-low and active-high syncs) sharing clock and reset.

module tb_display_timing_gen;
  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b0;
  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;

  // default timing
  logic [9:0]  a_sx, a_sy;
  logic        a_hs, a_vs, a_de, a_line, a_frame;
  logic [15:0] a_fc;
  // 7x6 total, active-low syncs, FRAMEW=2
  logic [9:0]  b_sx, b_sy;
  logic        b_hs, b_vs, b_de, b_line, b_frame;
  logic [1:0]  b_fc;
  // 10x7 total, active-high syncs, FRAMEW=3
  logic [9:0]  c_sx, c_sy;
  logic        c_hs, c_vs, c_de, c_line, c_frame;
  logic [2:0]  c_fc;

  display_timing_gen dut_a (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(a_sx), .sy(a_sy),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .line(a_line), .frame(a_frame),
    .frame_cnt(a_fc));

  display_timing_gen #(
    .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .FRAMEW(2)
  ) dut_b (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(b_sx), .sy(b_sy),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .line(b_line), .frame(b_frame),
    .frame_cnt(b_fc));

  display_timing_gen #(
    .H_RES(4), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_RES(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .FRAMEW(3)
  ) dut_c (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(c_sx), .sy(c_sy),
    .hsync(c_hs), .vsync(c_vs), .de(c_de), .line(c_line), .frame(c_frame),
    .frame_cnt(c_fc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_pix);
    #1;
  endtask

  typedef struct {
    int adv;
    int sx, sy;
    bit hs, vs, de, line, frame;
    int fc;
  } vec_t;
  vec_t vt[15];

  int hs_low, hs_first, hs_last, de_cnt, line_cnt, frame_cnt_a, a_pos_err;
  int b_err, b_fc_err, c_err, c_fc_err;

  initial begin
    // small instance, times relative to first edge after release
    vt[0]  = '{0,  0, 0, 1, 1, 1, 1, 1, 0};
    vt[1]  = '{3,  3, 0, 1, 1, 1, 0, 0, 0};
    vt[2]  = '{1,  4, 0, 1, 1, 0, 0, 0, 0};
    vt[3]  = '{1,  5, 0, 0, 1, 0, 0, 0, 0};
    vt[4]  = '{1,  6, 0, 1, 1, 0, 0, 0, 0};
    vt[5]  = '{1,  0, 1, 1, 1, 1, 1, 0, 0};
    vt[6]  = '{14, 0, 3, 1, 1, 0, 1, 0, 0};
    vt[7]  = '{7,  0, 4, 1, 0, 0, 1, 0, 0};
    vt[8]  = '{6,  6, 4, 1, 0, 0, 0, 0, 0};
    vt[9]  = '{1,  0, 5, 1, 1, 0, 1, 0, 0};
    vt[10] = '{6,  6, 5, 1, 1, 0, 0, 0, 0};
    vt[11] = '{1,  0, 0, 1, 1, 1, 1, 1, 1};
    vt[12] = '{42, 0, 0, 1, 1, 1, 1, 1, 2};
    vt[13] = '{42, 0, 0, 1, 1, 1, 1, 1, 3};
    vt[14] = '{42, 0, 0, 1, 1, 1, 1, 1, 0};

    // reset state
    step(5);
    chk("rst_a_sx", a_sx, 799);
    chk("rst_a_sy", a_sy, 524);
    chk("rst_a_flags", {a_hs, a_vs, a_de, a_line, a_frame}, 5'b11000);
    chk("rst_a_fc", a_fc, 0);
    chk("rst_b_pos", {b_sx, b_sy}, {10'd6, 10'd5});
    chk("rst_c_sync", {c_hs, c_vs}, 2'b00);

    rst_pix_n = 1'b1;
    step(1);
    chk("first_a_pos", {a_sx, a_sy}, 0);
    chk("first_a_flags", {a_hs, a_vs, a_de, a_line, a_frame}, 5'b11111);

    // free-run two lines of the default instance against an index model
    hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 0; line_cnt = 0;
    frame_cnt_a = 0; a_pos_err = 0; b_err = 0; b_fc_err = 0; c_err = 0; c_fc_err = 0;
    for (int i = 0; i <= 1600; i++) begin
      if (i > 0) step(1);
      if (a_sx != 10'(i % 800) || a_sy != 10'(i / 800)) a_pos_err++;
      if (i < 800) begin
        if (!a_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = i;
          hs_last = i;
        end
        if (a_de) de_cnt++;
      end
      if (a_line) line_cnt++;
      if (a_frame) frame_cnt_a++;
      begin
        int bx, by, cx, cy;
        bx = i % 7;  by = (i / 7) % 6;
        cx = i % 10; cy = (i / 10) % 7;
        if (b_sx != 10'(bx) || b_sy != 10'(by) || b_hs != (bx != 5) || b_vs != (by != 4) ||
            b_de != (bx < 4 && by < 3) || b_line != (bx == 0) || b_frame != (i % 42 == 0))
          b_err++;
        if (b_fc != 2'((i / 42) % 4)) b_fc_err++;
        if (c_sx != 10'(cx) || c_sy != 10'(cy) || c_hs != (cx >= 6 && cx <= 8) ||
            c_vs != (cy >= 4 && cy <= 5) || c_de != (cx < 4 && cy < 3) ||
            c_line != (cx == 0) || c_frame != (i % 70 == 0))
          c_err++;
        if (c_fc != 3'((i / 70) % 8)) c_fc_err++;
      end
    end
    chk("a_pos_track", a_pos_err, 0);
    chk("a_hs_low_cnt", hs_low, 96);
    chk("a_hs_first", hs_first, 656);
    chk("a_hs_last", hs_last, 751);
    chk("a_de_cnt_line0", de_cnt, 640);
    chk("a_line_cnt", line_cnt, 3);
    chk("a_frame_cnt", frame_cnt_a, 1);
    chk("b_model", b_err, 0);
    chk("b_fc_model", b_fc_err, 0);
    chk("c_model", c_err, 0);
    chk("c_fc_model", c_fc_err, 0);

    // mid-frame reset while hsync is active
    step(700);
    chk("pre_a_pos", {a_sx, a_sy}, {10'd700, 10'd2});
    chk("pre_a_hs", a_hs, 0);
    chk("pre_b_fc", b_fc, 2);
    rst_pix_n = 1'b0;
    #1;
    chk("async_a_pos", {a_sx, a_sy}, {10'd799, 10'd524});
    chk("async_a_flags", {a_hs, a_vs, a_de, a_line, a_frame}, 5'b11000);
    chk("async_b_fc", b_fc, 0);
    chk("async_c_sync", {c_hs, c_vs}, 2'b00);
    step(3);
    chk("hold_a_pos", {a_sx, a_sy}, {10'd799, 10'd524});
    chk("hold_a_hs", a_hs, 1);
    rst_pix_n = 1'b1;
    step(1);
    chk("rel_a_pos", {a_sx, a_sy}, 0);
    chk("rel_a_frame", a_frame, 1);
    chk("rel_a_fc", a_fc, 0);
    chk("rel_c_sync", {c_hs, c_vs}, 2'b00);

    foreach (vt[k]) begin
      if (vt[k].adv > 0) step(vt[k].adv);
      chk($sformatf("vec%0d_sx", k), b_sx, vt[k].sx);
      chk($sformatf("vec%0d_sy", k), b_sy, vt[k].sy);
      chk($sformatf("vec%0d_flags", k), {b_hs, b_vs, b_de, b_line, b_frame},
          {vt[k].hs, vt[k].vs, vt[k].de, vt[k].line, vt[k].frame});
      chk($sformatf("vec%0d_fc", k), b_fc, vt[k].fc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
